// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/PC controller.
// Holds the sequencer state encoding, the RV32I branch funct3 codes and
// the default datapath width used by branch_pc_ctrl and branch_cond.
package branch_pkg;

    // Default datapath width (PC, jump/branch target).
    localparam int XLEN_DEFAULT = 32;

    // Sequencer states of the non-pipelined fetch/execute loop.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // B-type funct3 encodings. 010 and 011 are unused and never taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps funct3 and the comparator flags to a
// single taken/not-taken condition. Purely combinational.
//
// The upstream comparator only provides an unsigned less-than. The signed
// less-than is rebuilt from the operand sign bits: when the signs differ,
// the negative operand (msb set) is the smaller one; when they agree, the
// unsigned ordering of two same-signed two's-complement values equals the
// signed ordering.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    input  logic       rs1_msb_i,
    input  logic       rs2_msb_i,
    output logic       cond_o
);

    logic lt_s;

    assign lt_s = (rs1_msb_i != rs2_msb_i) ? rs1_msb_i : br_lt_i;

    // Select the branch condition for the current funct3.
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = br_eq_i;
            F3_BNE:  cond_o = ~br_eq_i;
            F3_BLT:  cond_o = lt_s;
            F3_BGE:  cond_o = ~lt_s;
            F3_BLTU: cond_o = br_lt_i;
            F3_BGEU: cond_o = ~br_lt_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Branch/PC controller for a non-pipelined RV32I core.
//
// Owns the architectural PC, sequences FETCH -> EXEC -> FETCH, resolves
// conditional branches, JAL and JALR, and halts with a sticky trap when a
// taken control transfer lands on a target that is not 4-byte aligned.
//
// Handshakes: in FETCH imem_req is high until imem_ack is seen at a clock
// edge; in EXEC the controller waits for ex_done, at which edge all
// instruction inputs are sampled and the PC is updated. imem_ack outside
// FETCH and ex_done outside EXEC are ignored. HALT drops every handshake
// and is left only through rst.
//
// Optional feature (macro BRANCH_PC_CTRL_PERF_EN): adds saturating counters
// perf_br_cnt / perf_taken_cnt for committed and committed-taken B-type
// instructions. Without the macro those ports and counters do not exist.
//
// dbg_state exposes the sequencer state for observation.
module branch_pc_ctrl
    import branch_pkg::*;
#(
    parameter int             XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ack,
    input  logic            ex_done,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic            rs1_msb,
    input  logic            rs2_msb,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic            commit,
    output logic            br_taken,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
`ifdef BRANCH_PC_CTRL_PERF_EN
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_taken_cnt,
`endif
    output logic [1:0]      dbg_state
);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] trap_pc_q;
    logic            commit_q;
    logic            br_taken_q;
    logic            trap_q;

    logic            cond;
    logic            br_sel;
    logic            take_d;
    logic            misalign_d;
    logic [XLEN-1:0] next_pc_d;
    logic            retire;

    branch_cond u_cond (
        .funct3_i  (funct3),
        .br_eq_i   (br_eq),
        .br_lt_i   (br_lt),
        .rs1_msb_i (rs1_msb),
        .rs2_msb_i (rs2_msb),
        .cond_o    (cond)
    );

    // Link value; wraps naturally modulo 2^XLEN.
    assign pc_plus4 = pc_q + {{(XLEN-3){1'b0}}, 3'b100};

    // Resolve the control transfer of the instruction in EXEC.
    // Priority when several type flags are set: JALR > JAL > branch.
    always_comb begin
        br_sel     = is_branch & ~is_jal & ~is_jalr;
        take_d     = is_jalr | is_jal | (br_sel & cond);
        next_pc_d  = pc_plus4;
        if (is_jalr) begin
            next_pc_d = {target[XLEN-1:1], 1'b0};
        end else if (take_d) begin
            next_pc_d = target;
        end
        misalign_d = take_d & (next_pc_d[1:0] != 2'b00);
    end

    // An instruction retires when EXEC completes without a misaligned target.
    assign retire = (state_q == EXEC) & ex_done & ~misalign_d;

    // Sequencer, PC register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            commit_q   <= 1'b0;
            br_taken_q <= 1'b0;
            trap_q     <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        if (misalign_d) begin
                            state_q   <= HALT;
                            trap_q    <= 1'b1;
                            trap_pc_q <= pc_q;
                        end else begin
                            state_q    <= FETCH;
                            pc_q       <= next_pc_d;
                            commit_q   <= 1'b1;
                            br_taken_q <= take_d;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign imem_req  = (state_q == FETCH);
    assign commit    = commit_q;
    assign br_taken  = br_taken_q;
    assign trap      = trap_q;
    assign trap_pc   = trap_pc_q;
    assign dbg_state = state_q;

`ifdef BRANCH_PC_CTRL_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_taken_q;

    // Saturating counts of retired B-type and retired taken B-type instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q    <= '0;
            perf_taken_q <= '0;
        end else if (retire && br_sel) begin
            if (perf_br_q != 32'hFFFF_FFFF) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (cond && (perf_taken_q != 32'hFFFF_FFFF)) begin
                perf_taken_q <= perf_taken_q + 32'd1;
            end
        end
    end

    assign perf_br_cnt    = perf_br_q;
    assign perf_taken_cnt = perf_taken_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: directed scenarios plus a
// randomized run checked against an operand-level reference model.
module tb_branch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic        ex_done;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic        br_eq;
  logic        br_lt;
  logic        rs1_msb;
  logic        rs2_msb;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        commit;
  logic        br_taken;
  logic        trap;
  logic [31:0] trap_pc;
  logic [1:0]  dbg_state;
`ifdef BRANCH_PC_CTRL_PERF_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_taken_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];

  branch_pc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .imem_ack  (imem_ack),
    .ex_done   (ex_done),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .funct3    (funct3),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .rs1_msb   (rs1_msb),
    .rs2_msb   (rs2_msb),
    .target    (target),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .imem_req  (imem_req),
    .commit    (commit),
    .br_taken  (br_taken),
    .trap      (trap),
    .trap_pc   (trap_pc),
`ifdef BRANCH_PC_CTRL_PERF_EN
    .perf_br_cnt    (perf_br_cnt),
    .perf_taken_cnt (perf_taken_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fields();
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    funct3    = 3'b000;
    br_eq     = 1'b0;
    br_lt     = 1'b0;
    rs1_msb   = 1'b0;
    rs2_msb   = 1'b0;
    target    = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Works on full operand values: signed/unsigned ordering straight from
  // the operands, not from the comparator flags.
  function automatic void ref_exec(input bit b, input bit j, input bit jr,
                                   input logic [2:0] f3,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] tgt, input logic [31:0] cur_pc,
                                   output bit take, output logic [31:0] npc,
                                   output bit trp, output bit cnd);
    case (f3)
      3'b000:  cnd = (rs1 == rs2);
      3'b001:  cnd = (rs1 != rs2);
      3'b100:  cnd = ($signed(rs1) < $signed(rs2));
      3'b101:  cnd = ($signed(rs1) >= $signed(rs2));
      3'b110:  cnd = (rs1 < rs2);
      3'b111:  cnd = (rs1 >= rs2);
      default: cnd = 1'b0;
    endcase
    if (jr) begin
      take = 1'b1;
      npc  = tgt - (tgt % 2);
    end else if (j) begin
      take = 1'b1;
      npc  = tgt;
    end else if (b && cnd) begin
      take = 1'b1;
      npc  = tgt;
    end else begin
      take = 1'b0;
      npc  = cur_pc + 32'd4;
    end
    trp = take && ((npc % 4) != 0);
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction from FETCH through the ex_done edge. Returns a
  // timeout flag and imem_req as seen in EXEC. On return the ex_done edge
  // has just happened and the post-execute outputs are stable.
  task automatic run_instr(input bit b, input bit j, input bit jr,
                           input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] tgt,
                           output bit tmo, output logic req_exec);
    int n;
    n = 0;
    tmo = 1'b0;
    req_exec = 1'bx;
    // ex_done while fetching must be ignored
    clear_fields();
    is_jal  = 1'b1;
    target  = 32'h0000_0080;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    clear_fields();
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      tmo = 1'b1;
      return;
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    req_exec = imem_req;
    repeat ($urandom_range(0, 2)) begin
      imem_ack = 1'($urandom_range(0, 1));
      step();
    end
    imem_ack  = 1'b0;
    is_branch = b;
    is_jal    = j;
    is_jalr   = jr;
    funct3    = f3;
    br_eq     = (rs1 == rs2);
    br_lt     = (rs1 < rs2);
    rs1_msb   = rs1[31];
    rs2_msb   = rs2[31];
    target    = tgt;
    ex_done   = 1'b1;
    step();
    ex_done = 1'b0;
    clear_fields();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit tmo;
    logic req_exec;
    do_reset();
    total_cnt++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else pass_cnt++;
    total_cnt++; if (commit !== 1'b0) $display("FAIL reset_commit: got %b want 0", commit); else pass_cnt++;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL reset_br_taken: got %b want 0", br_taken); else pass_cnt++;
    total_cnt++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b want 0", trap); else pass_cnt++;
    total_cnt++; if (trap_pc !== 32'h0) $display("FAIL reset_trap_pc: got %h want 0", trap_pc); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL reset_imem_req: got %b want 1", imem_req); else pass_cnt++;
    total_cnt++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); else pass_cnt++;
    run_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h1, 32'h2, 32'h100, tmo, req_exec);
    total_cnt++; if (tmo) $display("FAIL fetch_timeout: got timeout want imem_req"); else pass_cnt++;
    total_cnt++; if (req_exec !== 1'b0) $display("FAIL exec_imem_req: got %b want 0", req_exec); else pass_cnt++;
    total_cnt++; if (pc !== 32'h4) $display("FAIL fetch_pc: got %h want %h", pc, 32'h4); else pass_cnt++;
    total_cnt++; if (commit !== 1'b1) $display("FAIL fetch_commit: got %b want 1", commit); else pass_cnt++;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL fetch_br_taken: got %b want 0", br_taken); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL fetch_req_after: got %b want 1", imem_req); else pass_cnt++;
    step();
    total_cnt++; if (commit !== 1'b0) $display("FAIL commit_pulse_width: got %b want 0", commit); else pass_cnt++;
  endtask

  task automatic test_signed_blt();
    bit tmo;
    logic req_exec;
    // pc is 4 here
    run_instr(1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, tmo, req_exec);
    total_cnt++; if (tmo || pc !== 32'h100) $display("FAIL blt_pc: got %h want %h", pc, 32'h100); else pass_cnt++;
    total_cnt++; if (br_taken !== 1'b1) $display("FAIL blt_taken: got %b want 1", br_taken); else pass_cnt++;
    step();
    run_instr(1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, tmo, req_exec);
    total_cnt++; if (tmo || pc !== 32'h104) $display("FAIL bltu_pc: got %h want %h", pc, 32'h104); else pass_cnt++;
    total_cnt++; if (br_taken !== 1'b0) $display("FAIL bltu_taken: got %b want 0", br_taken); else pass_cnt++;
    total_cnt++; if (commit !== 1'b1) $display("FAIL bltu_commit: got %b want 1", commit); else pass_cnt++;
    step();
  endtask

  task automatic test_jalr_align();
    bit tmo;
    logic req_exec;
    // pc is 0x104 here; 0x203 -> 0x202 is misaligned
    run_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h203, tmo, req_exec);
    total_cnt++; if (tmo || trap !== 1'b1) $display("FAIL jalr_trap: got %b want 1", trap); else pass_cnt++;
    total_cnt++; if (trap_pc !== 32'h104) $display("FAIL jalr_trap_pc: got %h want %h", trap_pc, 32'h104); else pass_cnt++;
    total_cnt++; if (pc !== 32'h104) $display("FAIL jalr_trap_pc_hold: got %h want %h", pc, 32'h104); else pass_cnt++;
    total_cnt++; if (commit !== 1'b0) $display("FAIL jalr_trap_commit: got %b want 0", commit); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      ex_done  = 1'b1;
      is_jal   = 1'b1;
      target   = 32'h0000_0040;
      step();
      imem_ack = 1'b0;
      ex_done  = 1'b0;
      clear_fields();
      total_cnt++;
      if (pc !== 32'h104 || trap !== 1'b1 || commit !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL halt_hold[%0d]: got pc=%h trap=%b commit=%b req=%b want pc=00000104 trap=1 commit=0 req=0",
                 i, pc, trap, commit, imem_req);
      else pass_cnt++;
      step();
    end
    do_reset();
    total_cnt++; if (trap !== 1'b0) $display("FAIL halt_reset_trap: got %b want 0", trap); else pass_cnt++;
    run_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h205, tmo, req_exec);
    total_cnt++; if (tmo || pc !== 32'h204) $display("FAIL jalr_clear_lsb_pc: got %h want %h", pc, 32'h204); else pass_cnt++;
    total_cnt++; if (commit !== 1'b1 || trap !== 1'b0) $display("FAIL jalr_clear_lsb_commit: got commit=%b trap=%b want 1/0", commit, trap); else pass_cnt++;
    total_cnt++; if (br_taken !== 1'b1) $display("FAIL jalr_br_taken: got %b want 1", br_taken); else pass_cnt++;
    step();
  endtask

  task automatic test_misaligned_branch();
    bit tmo;
    logic req_exec;
    // pc is 0x204 here
    run_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h55, 32'h102, tmo, req_exec);
    total_cnt++; if (tmo || trap !== 1'b1) $display("FAIL beq_mis_trap: got %b want 1", trap); else pass_cnt++;
    total_cnt++; if (pc !== 32'h204 || trap_pc !== 32'h204) $display("FAIL beq_mis_pc: got pc=%h trap_pc=%h want 00000204", pc, trap_pc); else pass_cnt++;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0, 3'b001, 32'h55, 32'h55, 32'h102, tmo, req_exec);
    total_cnt++; if (tmo || trap !== 1'b0) $display("FAIL bne_nt_trap: got %b want 0", trap); else pass_cnt++;
    total_cnt++; if (pc !== 32'h4) $display("FAIL bne_nt_pc: got %h want %h", pc, 32'h4); else pass_cnt++;
    step();
  endtask

  task automatic test_wrap_and_reset_mid();
    bit tmo;
    logic req_exec;
    run_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, tmo, req_exec);
    total_cnt++; if (tmo || pc !== 32'hFFFF_FFFC) $display("FAIL jal_high_pc: got %h want FFFFFFFC", pc); else pass_cnt++;
    total_cnt++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); else pass_cnt++;
    step();
    run_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h1, 32'h2, 32'h100, tmo, req_exec);
    total_cnt++; if (tmo || pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc); else pass_cnt++;
    step();
    run_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h40, tmo, req_exec);
    step();
    // now in FETCH at pc 0x40: move to EXEC, then reset with ex_done high
    total_cnt++; if (imem_req !== 1'b1 || pc !== 32'h40) $display("FAIL pre_mid_reset: got req=%b pc=%h want 1/00000040", imem_req, pc); else pass_cnt++;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    is_jal   = 1'b1;
    target   = 32'h80;
    ex_done  = 1'b1;
    rst      = 1'b1;
    step();
    rst     = 1'b0;
    ex_done = 1'b0;
    clear_fields();
    total_cnt++; if (pc !== 32'h0) $display("FAIL mid_reset_pc: got %h want 0", pc); else pass_cnt++;
    total_cnt++; if (commit !== 1'b0 || br_taken !== 1'b0) $display("FAIL mid_reset_commit: got commit=%b taken=%b want 0/0", commit, br_taken); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL mid_reset_req: got %b want 1", imem_req); else pass_cnt++;
    step();
    total_cnt++; if (commit !== 1'b0 || pc !== 32'h0) $display("FAIL mid_reset_after: got commit=%b pc=%h want 0/0", commit, pc); else pass_cnt++;
  endtask

  task automatic test_random();
    bit tmo;
    logic req_exec;
    bit b, j, jr, take, trp, cnd;
    logic [2:0] f3;
    logic [31:0] rs1, rs2, tgt, npc, m_pc, exp_pc;
    int m_br, m_tk;
    do_reset();
    m_pc = 32'h0;
    m_br = 0;
    m_tk = 0;
    for (int i = 0; i < 150; i++) begin
      b   = 1'($urandom_range(0, 1));
      j   = ($urandom_range(0, 3) == 0);
      jr  = ($urandom_range(0, 4) == 0);
      f3  = 3'($urandom_range(0, 7));
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) rs2 = {~rs1[31], rs2[30:0]};
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt = {tgt[31:2], 2'b00};
      ref_exec(b, j, jr, f3, rs1, rs2, tgt, m_pc, take, npc, trp, cnd);
      exp_q.push_back(trp ? m_pc : npc);
      run_instr(b, j, jr, f3, rs1, rs2, tgt, tmo, req_exec);
      exp_pc = exp_q.pop_front();
      total_cnt++;
      if (tmo || pc !== exp_pc)
        $display("FAIL rand_pc[%0d]: got %h want %h (b=%b j=%b jr=%b f3=%0d rs1=%h rs2=%h tgt=%h)",
                 i, pc, exp_pc, b, j, jr, f3, rs1, rs2, tgt);
      else pass_cnt++;
      if (trp) begin
        total_cnt++;
        if (trap !== 1'b1 || trap_pc !== m_pc || commit !== 1'b0)
          $display("FAIL rand_trap[%0d]: got trap=%b trap_pc=%h commit=%b want 1/%h/0", i, trap, trap_pc, commit, m_pc);
        else pass_cnt++;
        do_reset();
        m_pc = 32'h0;
        m_br = 0;
        m_tk = 0;
      end else begin
        total_cnt++;
        if (trap !== 1'b0 || commit !== 1'b1 || br_taken !== take)
          $display("FAIL rand_commit[%0d]: got trap=%b commit=%b taken=%b want 0/1/%b", i, trap, commit, br_taken, take);
        else pass_cnt++;
        if (b && !j && !jr) begin
          m_br++;
          if (cnd) m_tk++;
        end
        m_pc = npc;
        step();
      end
    end
`ifdef BRANCH_PC_CTRL_PERF_EN
    total_cnt++;
    if (perf_br_cnt !== 32'(m_br) || perf_taken_cnt !== 32'(m_tk))
      $display("FAIL rand_perf: got %0d/%0d want %0d/%0d", perf_br_cnt, perf_taken_cnt, m_br, m_tk);
    else pass_cnt++;
`endif
  endtask

`ifdef BRANCH_PC_CTRL_PERF_EN
  task automatic test_perf();
    bit tmo;
    logic req_exec;
    do_reset();
    total_cnt++; if (perf_br_cnt !== 32'h0 || perf_taken_cnt !== 32'h0) $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_br_cnt, perf_taken_cnt); else pass_cnt++;
    run_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h7, 32'h7, 32'h10, tmo, req_exec); step();         // taken
    run_instr(1'b1, 1'b0, 1'b0, 3'b001, 32'h7, 32'h7, 32'h40, tmo, req_exec); step();         // not taken
    run_instr(1'b1, 1'b0, 1'b0, 3'b110, 32'h1, 32'h2, 32'h20, tmo, req_exec); step();         // taken
    run_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h30, tmo, req_exec); step();         // JAL, not counted
    run_instr(1'b1, 1'b0, 1'b0, 3'b111, 32'h1, 32'h2, 32'h40, tmo, req_exec); step();         // not taken
    run_instr(1'b1, 1'b0, 1'b0, 3'b101, 32'h5, 32'hFFFF_FFFD, 32'h80, tmo, req_exec); step(); // taken
    total_cnt++; if (perf_br_cnt !== 32'd5) $display("FAIL perf_br_cnt: got %0d want 5", perf_br_cnt); else pass_cnt++;
    total_cnt++; if (perf_taken_cnt !== 32'd3) $display("FAIL perf_taken_cnt: got %0d want 3", perf_taken_cnt); else pass_cnt++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst      = 1'b1;
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    clear_fields();
    test_reset();
    test_signed_blt();
    test_jalr_align();
    test_misaligned_branch();
    test_wrap_and_reset_mid();
    test_random();
`ifdef BRANCH_PC_CTRL_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion want finish");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end

endmodule
